draw_scheduler: RTL and testbench
=================================

DRAW_SCHEDULER -- requirements
Module: draw_scheduler

Interface
REQ-001 The block SHALL take these parameters, one per line (name, default, meaning):
- X_W, 8, VGA x-coordinate width.
- Y_W, 7, VGA y-coordinate width.
- C_W, 3, colour width.
- WD_CYCLES, 20000, watchdog limit per draw phase.
REQ-002 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk, in, 1, system clock.
- resetn, in, 1, asynchronous active-low reset.
- frame_tick, in, 1, one-cycle pulse per video frame.
- enable, in, 1, game running.
- client_done, in, 4, per-client phase-complete pulse.
- client_plot, in, 4, per-client plot strobe.
- client_x, in, 4*X_W, per-client x; client i occupies bits [i*X_W +: X_W].
- client_y, in, 4*Y_W, per-client y, same packing.
- client_colour, in, 4*C_W, per-client colour, same packing.
- client_start, out, 4, one-cycle start pulse per client.
- grant, out, 4, one-hot current owner of the VGA plotter.
- update, out, 1, one-cycle game-logic advance pulse.
- vga_x, out, X_W, muxed x.
- vga_y, out, Y_W, muxed y.
- vga_colour, out, C_W, muxed colour.
- vga_plot, out, 1, muxed plot strobe.
- busy, out, 1, frame sequence in progress.
- timeout, out, 1, sticky watchdog flag.
- overrun_count, out, 8, saturating count of dropped frame ticks.
REQ-003 Client indices SHALL be: 0 = erase bird, 1 = erase wall, 2 = draw wall, 3 = draw bird.

Function
REQ-004 The FSM SHALL have the states WAIT_FRAME, ERASE_BIRD, ERASE_WALL, UPDATE, DRAW_WALL and DRAW_BIRD.
REQ-005 WAIT_FRAME SHALL go to ERASE_BIRD when enable=1 and either frame_tick=1 or pending=1; otherwise it SHALL hold.
REQ-006 The draw-phase order SHALL be ERASE_BIRD -> ERASE_WALL -> UPDATE -> DRAW_WALL -> DRAW_BIRD -> WAIT_FRAME.
REQ-007 On the first cycle of each draw phase, client_start[i] for that phase's client SHALL be 1 for exactly one cycle; this output is registered.
REQ-008 grant SHALL be one-hot for the phase client for the whole phase, and SHALL be 0 in WAIT_FRAME and UPDATE.
REQ-009 client_done[i] SHALL be accepted only when grant[i]=1 and not on the start cycle; done from non-granted clients SHALL be ignored.
REQ-010 The FSM SHALL leave a phase on the cycle after an accepted done.
REQ-011 UPDATE SHALL last exactly one cycle with update=1, then go to DRAW_WALL.
REQ-012 When grant[i]=1, vga_x, vga_y and vga_colour SHALL be combinational selections of client i's fields and vga_plot SHALL equal client_plot[i]; when grant=0, vga_plot SHALL be 0 and vga_x, vga_y and vga_colour SHALL be 0.
REQ-013 A phase watchdog counter SHALL reset to 0 on phase entry; if it reaches WD_CYCLES-1 without an accepted done, the FSM SHALL advance as if done arrived and set timeout=1.
REQ-014 timeout SHALL be sticky and cleared only by reset.
REQ-015 A frame_tick while busy=1 SHALL set pending=1 and increment overrun_count, saturating at 255.
REQ-016 A second tick while pending=1 SHALL increment overrun_count only.
REQ-017 pending SHALL be cleared on the transition WAIT_FRAME -> ERASE_BIRD.
REQ-018 pending SHALL also be cleared whenever enable=0 in WAIT_FRAME.
REQ-019 A frame_tick arriving in the same cycle as DRAW_BIRD's exit SHALL set pending, count as an overrun, and start the next frame immediately.
REQ-020 enable=0 mid-frame SHALL NOT abort the frame; the sequence SHALL complete, and then the FSM SHALL hold in WAIT_FRAME.
REQ-021 busy SHALL be 1 in every state except WAIT_FRAME.

Reset
REQ-022 While resetn=0, asynchronously: state=WAIT_FRAME, pending=0, watchdog=0, client_start=0, grant=0, update=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0, busy=0, timeout=0, overrun_count=0.
REQ-023 Reset asserted mid-phase SHALL abort immediately with no further start or update pulse.
REQ-024 The first frame after reset release SHALL require a fresh frame_tick.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- enable=1, tick; each client asserts done 3 cycles after its start -> start pulses in order 0,1,(update),2,3; grant one-hot throughout; busy drops after the client-3 done.
- Client 1 never asserts done, WD_CYCLES=16 -> ERASE_WALL exits after 16 cycles, timeout=1, and the sequence continues to UPDATE.
- Two ticks during one frame -> overrun_count=2, and the next frame starts the cycle after returning to WAIT_FRAME.
- Client 3 asserts done while grant=0001 -> ignored; the phase stays ERASE_BIRD.
- Client 2 (draw wall) granted with client_plot[2]=1, x=0x55, y=0x22 -> vga_x=0x55, vga_y=0x22, vga_plot=1; client 0 plot activity does not reach vga_plot.
- resetn low during DRAW_WALL -> all outputs 0 immediately; after release, ticks with enable=0 -> no start pulses.

Source files
------------

// File: rtl/draw_scheduler.sv
// Frame-driven draw sequencer: hands the VGA plotter to four drawing clients in a
// fixed order, pulses game-logic update mid-frame, and guards each phase with a watchdog.
module draw_scheduler #(
   parameter int X_W       = 8,
   parameter int Y_W       = 7,
   parameter int C_W       = 3,
   parameter int WD_CYCLES = 20000
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               frame_tick,
   input  logic               enable,
   input  logic [3:0]         client_done,
   input  logic [3:0]         client_plot,
   input  logic [4*X_W-1:0]   client_x,
   input  logic [4*Y_W-1:0]   client_y,
   input  logic [4*C_W-1:0]   client_colour,
   output logic [3:0]         client_start,
   output logic [3:0]         grant,
   output logic               update,
   output logic [X_W-1:0]     vga_x,
   output logic [Y_W-1:0]     vga_y,
   output logic [C_W-1:0]     vga_colour,
   output logic               vga_plot,
   output logic               busy,
   output logic               timeout,
   output logic [7:0]         overrun_count
);

   localparam int WD_W = (WD_CYCLES > 2) ? $clog2(WD_CYCLES) : 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(WD_CYCLES - 1);

   localparam logic [2:0] WAIT_FRAME = 3'd0;
   localparam logic [2:0] ERASE_BIRD = 3'd1;
   localparam logic [2:0] ERASE_WALL = 3'd2;
   localparam logic [2:0] UPDATE     = 3'd3;
   localparam logic [2:0] DRAW_WALL  = 3'd4;
   localparam logic [2:0] DRAW_BIRD  = 3'd5;

   logic [2:0]      state;
   logic [2:0]      state_nxt;
   logic            pending;
   logic            pending_nxt;
   logic [WD_W-1:0] wd;
   logic            in_phase;
   logic            done_acc;
   logic            wd_expired;
   logic            phase_end;
   logic            state_change;

   function automatic logic [3:0] phase_grant(input logic [2:0] s);
      case (s)
         ERASE_BIRD: phase_grant = 4'b0001;
         ERASE_WALL: phase_grant = 4'b0010;
         DRAW_WALL:  phase_grant = 4'b0100;
         DRAW_BIRD:  phase_grant = 4'b1000;
         default:    phase_grant = 4'b0000;
      endcase
   endfunction

   assign grant        = phase_grant(state);
   assign in_phase     = |grant;
   assign busy         = (state != WAIT_FRAME);
   assign update       = (state == UPDATE);
   // A done during the start cycle belongs to the previous frame's client activity.
   assign done_acc     = |(client_done & grant & ~client_start);
   assign wd_expired   = in_phase && (wd == WD_LAST);
   assign phase_end    = in_phase && (done_acc || wd_expired);
   assign state_change = (state_nxt != state);

   always_comb begin
      state_nxt = state;
      case (state)
         WAIT_FRAME: if (enable && (frame_tick || pending)) state_nxt = ERASE_BIRD;
         ERASE_BIRD: if (phase_end) state_nxt = ERASE_WALL;
         ERASE_WALL: if (phase_end) state_nxt = UPDATE;
         UPDATE:     state_nxt = DRAW_WALL;
         DRAW_WALL:  if (phase_end) state_nxt = DRAW_BIRD;
         DRAW_BIRD:  if (phase_end) state_nxt = WAIT_FRAME;
         default:    state_nxt = WAIT_FRAME;
      endcase
   end

   always_comb begin
      pending_nxt = pending;
      if (state == WAIT_FRAME) begin
         if (!enable || state_nxt == ERASE_BIRD) pending_nxt = 1'b0;
      end else if (frame_tick) begin
         pending_nxt = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state         <= WAIT_FRAME;
         pending       <= 1'b0;
         wd            <= '0;
         client_start  <= 4'b0000;
         timeout       <= 1'b0;
         overrun_count <= 8'd0;
      end else begin
         state        <= state_nxt;
         pending      <= pending_nxt;
         client_start <= state_change ? phase_grant(state_nxt) : 4'b0000;
         if (state_change) wd <= '0;
         else if (in_phase) wd <= wd + WD_W'(1);
         if (wd_expired && !done_acc) timeout <= 1'b1;
         if (frame_tick && busy && overrun_count != 8'hff)
            overrun_count <= overrun_count + 8'd1;
      end
   end

   always_comb begin
      vga_x      = '0;
      vga_y      = '0;
      vga_colour = '0;
      vga_plot   = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (grant[i]) begin
            vga_x      = client_x[i*X_W +: X_W];
            vga_y      = client_y[i*Y_W +: Y_W];
            vga_colour = client_colour[i*C_W +: C_W];
            vga_plot   = client_plot[i];
         end
      end
   end

endmodule

// File: tb/tb_draw_scheduler.sv
// Bench for draw_scheduler: auto-responding clients, a pulse-order scoreboard and
// directed scenarios for ordering, watchdog, overruns, done filtering, muxing and reset.
module tb_draw_scheduler;

   localparam int X_W = 8;
   localparam int Y_W = 7;
   localparam int C_W = 3;

   logic               clk = 1'b0;
   logic               resetn = 1'b0;
   logic               frame_tick = 1'b0;
   logic               enable = 1'b0;
   logic [3:0]         auto_done = 4'b0;
   logic [3:0]         extra_done = 4'b0;
   logic [3:0]         auto_en = 4'hf;
   logic [3:0]         client_done;
   logic [3:0]         client_plot = 4'b0;
   logic [4*X_W-1:0]   client_x = '0;
   logic [4*Y_W-1:0]   client_y = '0;
   logic [4*C_W-1:0]   client_colour = '0;
   logic [3:0]         client_start;
   logic [3:0]         grant;
   logic               update;
   logic [X_W-1:0]     vga_x;
   logic [Y_W-1:0]     vga_y;
   logic [C_W-1:0]     vga_colour;
   logic               vga_plot;
   logic               busy;
   logic               timeout;
   logic [7:0]         overrun_count;

   int         checks = 0;
   int         failures = 0;
   logic [2:0] exp_q[$];
   bit         mon_en = 1'b1;
   int         cnt[4];
   logic [2:0] mon_code;

   assign client_done = auto_done | extra_done;

   draw_scheduler #(.X_W(X_W), .Y_W(Y_W), .C_W(C_W), .WD_CYCLES(16)) dut (
      .clk(clk), .resetn(resetn), .frame_tick(frame_tick), .enable(enable),
      .client_done(client_done), .client_plot(client_plot), .client_x(client_x),
      .client_y(client_y), .client_colour(client_colour), .client_start(client_start),
      .grant(grant), .update(update), .vga_x(vga_x), .vga_y(vga_y),
      .vga_colour(vga_colour), .vga_plot(vga_plot), .busy(busy), .timeout(timeout),
      .overrun_count(overrun_count)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Clients answer done three cycles after their start pulse.
   initial forever begin
      @(posedge clk);
      #2;
      for (int i = 0; i < 4; i++) begin
         auto_done[i] = 1'b0;
         if (!resetn) cnt[i] = 0;
         else if (client_start[i] && auto_en[i]) cnt[i] = 3;
         else if (cnt[i] > 0) begin
            cnt[i] = cnt[i] - 1;
            if (cnt[i] == 0) auto_done[i] = 1'b1;
         end
      end
   end

   // Scoreboard: codes 0..3 = start of that client, 4 = update.
   always @(negedge clk) begin
      if (resetn && mon_en && (|client_start || update)) begin
         mon_code = update ? 3'd4 :
                    client_start[0] ? 3'd0 : client_start[1] ? 3'd1 :
                    client_start[2] ? 3'd2 : 3'd3;
         check("pulse_onehot", $countones({client_start, update}), 1);
         if (exp_q.size() == 0) check("unexpected_pulse", {29'd0, mon_code}, 32'd7);
         else check("pulse_order", {29'd0, mon_code}, {29'd0, exp_q.pop_front()});
      end
   end

   task automatic push_frame();
      exp_q.push_back(3'd0);
      exp_q.push_back(3'd1);
      exp_q.push_back(3'd4);
      exp_q.push_back(3'd2);
      exp_q.push_back(3'd3);
   endtask

   task automatic pulse_tick();
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
   endtask

   task automatic reset_dut();
      resetn = 1'b0;
      frame_tick = 1'b0;
      enable = 1'b0;
      extra_done = 4'b0;
      auto_en = 4'hf;
      exp_q.delete();
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);
   endtask

   task automatic wait_grant(input string tag, input logic [3:0] g, input int limit);
      int n = 0;
      while (grant !== g && n < limit) begin
         @(negedge clk);
         n++;
      end
      check(tag, grant, g);
   endtask

   task automatic wait_idle(input string tag, input int limit);
      int n = 0;
      while (busy !== 1'b0 && n < limit) begin
         @(negedge clk);
         n++;
      end
      check(tag, busy, 0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_start"}, client_start, 0);
      check({tag, "_grant"}, grant, 0);
      check({tag, "_update"}, update, 0);
      check({tag, "_vga"}, {vga_x, vga_y, vga_colour, vga_plot}, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_timeout"}, timeout, 0);
      check({tag, "_overrun"}, overrun_count, 0);
   endtask

   initial begin
      int busy_cycles;
      int zero_grant;
      int wd_len;

      #2;
      check_all_zero("reset");
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);

      // Normal frame ordering
      enable = 1'b1;
      push_frame();
      pulse_tick();
      check("s1_first_start", client_start, 4'b0001);
      busy_cycles = 0;
      zero_grant = 0;
      while (busy && busy_cycles < 100) begin
         check("s1_grant_onehot0", $onehot0(grant), 1);
         if (grant == 4'b0) zero_grant++;
         busy_cycles++;
         @(negedge clk);
      end
      check("s1_busy_cycles", busy_cycles, 17);
      check("s1_update_cycles", zero_grant, 1);
      check("s1_queue_empty", exp_q.size(), 0);

      // Watchdog on erase wall
      reset_dut();
      enable = 1'b1;
      auto_en = 4'b1101;
      push_frame();
      check("s2_timeout_clear", timeout, 0);
      pulse_tick();
      wait_grant("s2_wait_erase_wall", 4'b0010, 10);
      wd_len = 0;
      while (grant == 4'b0010 && wd_len < 40) begin
         wd_len++;
         @(negedge clk);
      end
      check("s2_wd_phase_len", wd_len, 16);
      check("s2_timeout_set", timeout, 1);
      check("s2_then_update", update, 1);
      wait_idle("s2_idle", 60);
      check("s2_timeout_sticky", timeout, 1);
      auto_en = 4'hf;

      // Two overrun ticks, back-to-back frame
      reset_dut();
      enable = 1'b1;
      push_frame();
      pulse_tick();
      repeat (3) @(negedge clk);
      push_frame();
      pulse_tick();
      repeat (3) @(negedge clk);
      pulse_tick();
      wait_idle("s3_idle", 60);
      check("s3_overrun", overrun_count, 2);
      @(negedge clk);
      check("s3_restart_busy", busy, 1);
      check("s3_restart_start", client_start, 4'b0001);
      wait_idle("s3_idle2", 60);
      repeat (3) @(negedge clk);
      check("s3_stay_idle", busy, 0);
      check("s3_overrun_hold", overrun_count, 2);

      // Done filtering
      reset_dut();
      enable = 1'b1;
      auto_en = 4'b1110;
      push_frame();
      pulse_tick();
      extra_done = 4'b0001;
      @(negedge clk);
      check("s4_done_on_start_ignored", grant, 4'b0001);
      extra_done = 4'b1000;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("s4_foreign_done_ignored", grant, 4'b0001);
      end
      extra_done = 4'b0001;
      @(negedge clk);
      extra_done = 4'b0000;
      check("s4_advance", grant, 4'b0010);
      wait_idle("s4_idle", 60);
      check("s4_no_timeout", timeout, 0);
      auto_en = 4'hf;

      // VGA mux
      reset_dut();
      enable = 1'b1;
      client_x = {8'h44, 8'h55, 8'h33, 8'h11};
      client_y = {7'h01, 7'h22, 7'h03, 7'h0a};
      client_colour = {3'd7, 3'd5, 3'd2, 3'd1};
      client_plot = 4'b0001;
      #1;
      check("s5_idle_plot", vga_plot, 0);
      check("s5_idle_x", vga_x, 0);
      push_frame();
      pulse_tick();
      check("s5_c0_x", vga_x, 8'h11);
      check("s5_c0_plot", vga_plot, 1);
      wait_grant("s5_wait_draw_wall", 4'b0100, 30);
      client_plot = 4'b0101;
      #1;
      check("s5_c2_x", vga_x, 8'h55);
      check("s5_c2_y", vga_y, 7'h22);
      check("s5_c2_colour", vga_colour, 3'd5);
      check("s5_c2_plot", vga_plot, 1);
      client_plot = 4'b0001;
      #1;
      check("s5_c0_plot_blocked", vga_plot, 0);

      // Reset mid draw-wall
      client_plot = 4'b0101;
      check("s6_busy_before", busy, 1);
      resetn = 1'b0;
      exp_q.delete();
      #1;
      check_all_zero("s6_async");
      repeat (3) @(negedge clk);
      resetn = 1'b1;
      enable = 1'b0;
      for (int k = 0; k < 4; k++) begin
         pulse_tick();
         @(negedge clk);
         check("s6_disabled_idle", busy, 0);
      end
      enable = 1'b1;
      repeat (5) @(negedge clk);
      check("s6_needs_fresh_tick", busy, 0);
      check("s6_no_timeout", timeout, 0);
      client_plot = 4'b0;

      // Overrun saturation with a held tick
      mon_en = 1'b0;
      frame_tick = 1'b1;
      repeat (400) @(negedge clk);
      frame_tick = 1'b0;
      check("s7_overrun_sat", overrun_count, 8'hff);
      reset_dut();
      mon_en = 1'b1;
      check("s7_reset_overrun", overrun_count, 0);
      check("final_queue_empty", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
